// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: FSM state encoding, link register index and default widths.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int REG_W  = 5;
    localparam int LAST_REG_IDX = 31;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage inputs, run/step enable and write-back outputs of the MEM/WB stage.
interface mem_wb_stage_if #(
    parameter int DATA_SIZE = 32,
    parameter int PC_SIZE   = 32,
    parameter int REG_SIZE  = 5
);
    logic                 i_enable;
    logic                 i_valid;
    logic [DATA_SIZE-1:0] i_mem_data;
    logic [DATA_SIZE-1:0] i_alu_result;
    logic [REG_SIZE-1:0]  i_selected_reg;
    logic                 i_reg_write;
    logic                 i_mem_to_reg;
    logic                 i_last_register_ctrl;
    logic [PC_SIZE-1:0]   i_pc;
    logic                 i_halt;

    logic [DATA_SIZE-1:0] o_write_data;
    logic [REG_SIZE-1:0]  o_write_reg;
    logic                 o_reg_write;
    logic                 o_fwd_en;
    logic [REG_SIZE-1:0]  o_fwd_reg;
    logic [DATA_SIZE-1:0] o_fwd_data;
    logic [31:0]          o_instr_count;
    logic                 o_halt;

    modport master (
        output i_enable, i_valid, i_mem_data, i_alu_result, i_selected_reg,
               i_reg_write, i_mem_to_reg, i_last_register_ctrl, i_pc, i_halt,
        input  o_write_data, o_write_reg, o_reg_write, o_fwd_en, o_fwd_reg,
               o_fwd_data, o_instr_count, o_halt
    );

    modport slave (
        input  i_enable, i_valid, i_mem_data, i_alu_result, i_selected_reg,
               i_reg_write, i_mem_to_reg, i_last_register_ctrl, i_pc, i_halt,
        output o_write_data, o_write_reg, o_reg_write, o_fwd_en, o_fwd_reg,
               o_fwd_data, o_instr_count, o_halt
    );
endinterface

// File: rtl/mem_wb_stage_wb_mux.sv
// Write-back select: link writes the PC to LAST_REG, loads write memory data, else ALU result.
module mem_wb_stage_wb_mux #(
    parameter int DATA_SIZE = 32,
    parameter int PC_SIZE   = 32,
    parameter int REG_SIZE  = 5,
    parameter int LAST_REG  = 31
) (
    input  logic [DATA_SIZE-1:0] i_mem_data,
    input  logic [DATA_SIZE-1:0] i_alu_result,
    input  logic [PC_SIZE-1:0]   i_pc,
    input  logic [REG_SIZE-1:0]  i_selected_reg,
    input  logic                 i_mem_to_reg,
    input  logic                 i_last_register_ctrl,
    output logic [DATA_SIZE-1:0] o_write_data,
    output logic [REG_SIZE-1:0]  o_write_reg
);
    always_comb begin
        o_write_data = i_alu_result;
        o_write_reg  = i_selected_reg;
        if (i_last_register_ctrl) begin
            o_write_data = DATA_SIZE'(i_pc);
            o_write_reg  = REG_SIZE'(LAST_REG);
        end else if (i_mem_to_reg) begin
            o_write_data = i_mem_data;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, single-shot write strobe,
// retired-instruction counter and sticky halt state.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_SIZE = DATA_W,
    parameter int PC_SIZE   = PC_W,
    parameter int REG_SIZE  = REG_W,
    parameter int LAST_REG  = LAST_REG_IDX
) (
    input  logic          i_clock,
    input  logic          i_reset,
    mem_wb_stage_if.slave bus
);
    logic                 r_valid;
    logic [DATA_SIZE-1:0] r_mem_data;
    logic [DATA_SIZE-1:0] r_alu_result;
    logic [REG_SIZE-1:0]  r_selected_reg;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_last_register_ctrl;
    logic [PC_SIZE-1:0]   r_pc;
    logic                 r_halt;
    logic                 r_fresh;
    logic [0:0]           r_state;
    logic [31:0]          r_instr_count;

    logic                 w_run;
    logic                 w_halt_now;
    logic                 w_capture;
    logic                 w_dest_ok;
    logic                 w_fwd_en;
    logic [DATA_SIZE-1:0] w_write_data;
    logic [REG_SIZE-1:0]  w_write_reg;

    assign w_run      = (r_state == ST_RUN);
    assign w_halt_now = r_fresh & r_valid & r_halt & w_run;
    // A halt being retired this edge blocks the younger instruction behind it.
    assign w_capture  = bus.i_enable & w_run & ~w_halt_now;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid              <= 1'b0;
            r_mem_data           <= '0;
            r_alu_result         <= '0;
            r_selected_reg       <= '0;
            r_reg_write          <= 1'b0;
            r_mem_to_reg         <= 1'b0;
            r_last_register_ctrl <= 1'b0;
            r_pc                 <= '0;
            r_halt               <= 1'b0;
            r_fresh              <= 1'b0;
            r_state              <= ST_RUN;
            r_instr_count        <= '0;
        end else begin
            if (w_capture) begin
                r_valid              <= bus.i_valid;
                r_mem_data           <= bus.i_mem_data;
                r_alu_result         <= bus.i_alu_result;
                r_selected_reg       <= bus.i_selected_reg;
                r_reg_write          <= bus.i_reg_write;
                r_mem_to_reg         <= bus.i_mem_to_reg;
                r_last_register_ctrl <= bus.i_last_register_ctrl;
                r_pc                 <= bus.i_pc;
                r_halt               <= bus.i_halt;
            end
            r_fresh <= w_capture;
            if (w_halt_now)
                r_state <= ST_HALTED;
            if (r_fresh & r_valid & w_run)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    mem_wb_stage_wb_mux #(
        .DATA_SIZE (DATA_SIZE),
        .PC_SIZE   (PC_SIZE),
        .REG_SIZE  (REG_SIZE),
        .LAST_REG  (LAST_REG)
    ) u_wb_mux (
        .i_mem_data           (r_mem_data),
        .i_alu_result         (r_alu_result),
        .i_pc                 (r_pc),
        .i_selected_reg       (r_selected_reg),
        .i_mem_to_reg         (r_mem_to_reg),
        .i_last_register_ctrl (r_last_register_ctrl),
        .o_write_data         (w_write_data),
        .o_write_reg          (w_write_reg)
    );

    // Forwarding ignores r_fresh so a stalled consumer still sees the value.
    assign w_dest_ok = (w_write_reg != '0);
    assign w_fwd_en  = r_valid & r_reg_write & w_dest_ok & w_run;

    assign bus.o_write_data  = w_write_data;
    assign bus.o_write_reg   = w_write_reg;
    assign bus.o_reg_write   = r_fresh & w_fwd_en;
    assign bus.o_fwd_en      = w_fwd_en;
    assign bus.o_fwd_reg     = w_write_reg;
    assign bus.o_fwd_data    = w_write_data;
    assign bus.o_instr_count = r_instr_count;
    assign bus.o_halt        = (r_state == ST_HALTED);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed checks of the MEM/WB stage: ALU/load/link write-back, stall, r0, halt, reset, wrap.
module tb_mem_wb_stage;
    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 i_clock = ~i_clock;

    mem_wb_stage_if #(.DATA_SIZE(32), .PC_SIZE(32), .REG_SIZE(5)) bus ();

    mem_wb_stage #(
        .DATA_SIZE (32),
        .PC_SIZE   (32),
        .REG_SIZE  (5),
        .LAST_REG  (31)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic vld, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                         input logic m2r, input logic lrc, input logic [31:0] pc,
                         input logic hlt);
        bus.i_enable             = en;
        bus.i_valid              = vld;
        bus.i_mem_data           = mem;
        bus.i_alu_result         = alu;
        bus.i_selected_reg       = rd;
        bus.i_reg_write          = rw;
        bus.i_mem_to_reg         = m2r;
        bus.i_last_register_ctrl = lrc;
        bus.i_pc                 = pc;
        bus.i_halt               = hlt;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wdata"}, bus.o_write_data, 32'h0);
        check({tag, "_wreg"},  32'(bus.o_write_reg), 32'd0);
        check({tag, "_strobe"}, 32'(bus.o_reg_write), 32'd0);
        check({tag, "_fwd"},   32'(bus.o_fwd_en), 32'd0);
        check({tag, "_count"}, bus.o_instr_count, 32'd0);
        check({tag, "_halt"},  32'(bus.o_halt), 32'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        check_zero_outputs("reset");
        i_reset = 1'b0;

        // ALU write: one enabled edge, then stall
        drive(1'b1, 1'b1, 32'h0, 32'h1234, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("alu_wdata",  bus.o_write_data, 32'h1234);
        check("alu_wreg",   32'(bus.o_write_reg), 32'd8);
        check("alu_strobe", 32'(bus.o_reg_write), 32'd1);
        check("alu_fwd_reg", 32'(bus.o_fwd_reg), 32'd8);
        bus.i_enable = 1'b0;
        step();
        check("alu_strobe_off", 32'(bus.o_reg_write), 32'd0);
        check("alu_count",  bus.o_instr_count, 32'd1);

        // Load then a 3-cycle stall
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h5555, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        check("ld_wdata",  bus.o_write_data, 32'hDEADBEEF);
        check("ld_wreg",   32'(bus.o_write_reg), 32'd9);
        check("ld_strobe", 32'(bus.o_reg_write), 32'd1);
        bus.i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld_stall_strobe", 32'(bus.o_reg_write), 32'd0);
            check("ld_stall_fwd",    32'(bus.o_fwd_en), 32'd1);
            check("ld_stall_fdata",  bus.o_fwd_data, 32'hDEADBEEF);
        end
        check("ld_count", bus.o_instr_count, 32'd2);

        // Link write goes to r31 with the PC value
        drive(1'b1, 1'b1, 32'h99, 32'h7, 5'd5, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        step();
        check("lnk_wdata",  bus.o_write_data, 32'h40);
        check("lnk_wreg",   32'(bus.o_write_reg), 32'd31);
        check("lnk_strobe", 32'(bus.o_reg_write), 32'd1);
        // Destination r0: never written, never forwarded, still retired
        drive(1'b1, 1'b1, 32'h0, 32'hABCD, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("r0_strobe", 32'(bus.o_reg_write), 32'd0);
        check("r0_fwd",    32'(bus.o_fwd_en), 32'd0);
        bus.i_enable = 1'b0;
        step();
        check("r0_count", bus.o_instr_count, 32'd4);

        // One more retire to reach 5, then reset together with enable
        drive(1'b1, 1'b1, 32'h0, 32'h5, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        bus.i_enable = 1'b0;
        step();
        check("pre_rst_count", bus.o_instr_count, 32'd5);
        drive(1'b1, 1'b1, 32'h0, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        i_reset = 1'b1;
        step();
        check_zero_outputs("midrst");
        i_reset = 1'b0;
        step();
        check("post_rst_strobe", 32'(bus.o_reg_write), 32'd1);
        check("post_rst_wdata",  bus.o_write_data, 32'h77);
        bus.i_enable = 1'b0;
        step();
        check("post_rst_count", bus.o_instr_count, 32'd1);

        // Halt: bubble, ADD, HALT, ADD on consecutive enabled edges
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'hBAD, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("bub_strobe", 32'(bus.o_reg_write), 32'd0);
        drive(1'b1, 1'b1, 32'h0, 32'h11, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("add_strobe", 32'(bus.o_reg_write), 32'd1);
        check("add_count",  bus.o_instr_count, 32'd0);
        drive(1'b1, 1'b1, 32'h0, 32'h33, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("hlt_cap_count", bus.o_instr_count, 32'd1);
        check("hlt_cap_halt",  32'(bus.o_halt), 32'd0);
        drive(1'b1, 1'b1, 32'h0, 32'h22, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("hlt_halt",   32'(bus.o_halt), 32'd1);
        check("hlt_count",  bus.o_instr_count, 32'd2);
        check("hlt_strobe", 32'(bus.o_reg_write), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hlt_drop_wdata",  bus.o_write_data, 32'h33);
            check("hlt_drop_strobe", 32'(bus.o_reg_write), 32'd0);
            check("hlt_drop_fwd",    32'(bus.o_fwd_en), 32'd0);
            check("hlt_drop_count",  bus.o_instr_count, 32'd2);
            check("hlt_sticky",      32'(bus.o_halt), 32'd1);
        end

        // Halt presented with enable low is not captured
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_from_halted", 32'(bus.o_halt), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        step();
        check("hlt_noen_halt",  32'(bus.o_halt), 32'd0);
        check("hlt_noen_count", bus.o_instr_count, 32'd0);

        // Counter wrap
        force dut.r_instr_count = 32'hFFFFFFFF;
        #1;
        release dut.r_instr_count;
        #1;
        check("wrap_preload", bus.o_instr_count, 32'hFFFFFFFF);
        drive(1'b1, 1'b1, 32'h0, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        bus.i_enable = 1'b0;
        step();
        check("wrap_count", bus.o_instr_count, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
